// File: rtl/k007232_pkg.sv
// Shared constants and FSM state type for the K007232 sample-ROM arbiter.
package k007232_pkg;
  localparam int SA_W = 17;
  localparam int TMO_CYC = 255;
  localparam logic [7:0] END_MARK = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;
endpackage

// File: rtl/k007232_romarb_tag.sv
// One-entry address/data tag store for a single channel; only present when
// K007232_ROMARB_CACHE_EN is defined.
module k007232_romarb_tag
  import k007232_pkg::*;
(
  input  logic            CLK,
  input  logic            RES,
  input  logic            wr,
  input  logic            clr,
  input  logic [SA_W-1:0] wr_addr,
  input  logic [7:0]      wr_data,
  input  logic [SA_W-1:0] rd_addr,
  output logic            hit,
  output logic [7:0]      rd_data
);

  logic            valid;
  logic [SA_W-1:0] tag_addr;
  logic [7:0]      tag_data;

  // Invalidation wins over a same-cycle write.
  always_ff @(posedge CLK) begin
    if (RES) begin
      valid    <= 1'b0;
      tag_addr <= '0;
      tag_data <= END_MARK;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid    <= 1'b1;
      tag_addr <= wr_addr;
      tag_data <= wr_data;
    end
  end

  assign hit     = valid && (tag_addr == rd_addr);
  assign rd_data = tag_data;

endmodule

// File: rtl/k007232_romarb.sv
// Two-channel round-robin arbiter for the shared sample ROM, with 255-cycle
// read timeout. Optional per-channel one-entry cache: K007232_ROMARB_CACHE_EN.
module k007232_romarb
  import k007232_pkg::*;
(
  input  logic            CLK,
  input  logic            RES,
  input  logic            CH1_REQ,
  input  logic [SA_W-1:0] CH1_ADDR,
  output logic            CH1_ACK,
  output logic [7:0]      CH1_DATA,
  input  logic            CH2_REQ,
  input  logic [SA_W-1:0] CH2_ADDR,
  output logic            CH2_ACK,
  output logic [7:0]      CH2_DATA,
  output logic            ROM_RD,
  output logic [SA_W-1:0] ROM_A,
  input  logic            ROM_RDY,
  input  logic [7:0]      ROM_D,
  output logic            BUSY,
  output logic            TMO
);

  state_t          state;
  logic            ptr;
  logic            gnt;
  logic [7:0]      tmo_cnt;
  logic            grant_ch2;
  logic [SA_W-1:0] req_addr;
  logic            tmo_hit;
  logic [7:0]      fetch_data;
  logic            hit;
  logic [7:0]      hit_data;

  // Pointer only matters when both channels ask at once.
  always_comb begin
    grant_ch2 = CH2_REQ;
    if (CH1_REQ && CH2_REQ) grant_ch2 = ptr;
  end

  assign req_addr   = grant_ch2 ? CH2_ADDR : CH1_ADDR;
  assign tmo_hit    = (state == READ) && !ROM_RDY && (tmo_cnt == 8'(TMO_CYC - 1));
  assign fetch_data = ROM_RDY ? ROM_D : END_MARK;
  assign BUSY       = (state != IDLE);

`ifdef K007232_ROMARB_CACHE_EN
  logic       hit1, hit2;
  logic [7:0] tdata1, tdata2;
  logic       fill;

  assign fill = (state == READ) && ROM_RDY;

  k007232_romarb_tag u_tag1 (
    .CLK(CLK), .RES(RES), .wr(fill && !gnt), .clr(tmo_hit),
    .wr_addr(ROM_A), .wr_data(ROM_D), .rd_addr(CH1_ADDR),
    .hit(hit1), .rd_data(tdata1)
  );

  k007232_romarb_tag u_tag2 (
    .CLK(CLK), .RES(RES), .wr(fill && gnt), .clr(tmo_hit),
    .wr_addr(ROM_A), .wr_data(ROM_D), .rd_addr(CH2_ADDR),
    .hit(hit2), .rd_data(tdata2)
  );

  assign hit      = grant_ch2 ? hit2 : hit1;
  assign hit_data = grant_ch2 ? tdata2 : tdata1;
`else
  assign hit      = 1'b0;
  assign hit_data = END_MARK;
`endif

  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      tmo_cnt  <= '0;
      ROM_RD   <= 1'b0;
      ROM_A    <= '0;
      CH1_ACK  <= 1'b0;
      CH2_ACK  <= 1'b0;
      CH1_DATA <= END_MARK;
      CH2_DATA <= END_MARK;
      TMO      <= 1'b0;
    end else begin
      CH1_ACK <= 1'b0;
      CH2_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (CH1_REQ || CH2_REQ) begin
            gnt     <= grant_ch2;
            ROM_A   <= req_addr;
            tmo_cnt <= '0;
            if (hit) begin
              state <= DONE;
              if (grant_ch2) begin
                CH2_DATA <= hit_data;
                CH2_ACK  <= 1'b1;
              end else begin
                CH1_DATA <= hit_data;
                CH1_ACK  <= 1'b1;
              end
            end else begin
              state  <= READ;
              ROM_RD <= 1'b1;
            end
          end
        end
        READ: begin
          if (ROM_RDY || tmo_hit) begin
            state  <= DONE;
            ROM_RD <= 1'b0;
            if (tmo_hit) TMO <= 1'b1;
            if (gnt) begin
              CH2_DATA <= fetch_data;
              CH2_ACK  <= 1'b1;
            end else begin
              CH1_DATA <= fetch_data;
              CH1_ACK  <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ptr   <= ~ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k007232_romarb.sv
// Directed self-checking bench for k007232_romarb; expectations for the
// repeated-address case follow K007232_ROMARB_CACHE_EN.
module tb_k007232_romarb;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        CH1_REQ = 1'b0, CH2_REQ = 1'b0;
  logic [16:0] CH1_ADDR = '0, CH2_ADDR = '0;
  logic        CH1_ACK, CH2_ACK;
  logic [7:0]  CH1_DATA, CH2_DATA;
  logic        ROM_RD;
  logic [16:0] ROM_A;
  logic        ROM_RDY = 1'b0;
  logic [7:0]  ROM_D = '0;
  logic        BUSY, TMO;

  int n_cmp = 0;
  int n_err = 0;

  int  rom_delay = 0;
  bit  rom_stall = 0;
  int  rd_cycles = 0, last_rd = 0, rom_reads = 0;
  logic [16:0] rom_a_seen = '0;
  int  ack1_cnt = 0, ack2_cnt = 0, overlap = 0, rd_idle = 0;

  k007232_romarb dut (
    .CLK(CLK), .RES(RES),
    .CH1_REQ(CH1_REQ), .CH1_ADDR(CH1_ADDR), .CH1_ACK(CH1_ACK), .CH1_DATA(CH1_DATA),
    .CH2_REQ(CH2_REQ), .CH2_ADDR(CH2_ADDR), .CH2_ACK(CH2_ACK), .CH2_DATA(CH2_DATA),
    .ROM_RD(ROM_RD), .ROM_A(ROM_A), .ROM_RDY(ROM_RDY), .ROM_D(ROM_D),
    .BUSY(BUSY), .TMO(TMO)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ROM responder and ACK/strobe monitor, both sampled mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (CH1_ACK) ack1_cnt++;
      if (CH2_ACK) ack2_cnt++;
      if (CH1_ACK && CH2_ACK) overlap++;
      if (ROM_RD && !BUSY) rd_idle++;
      if (ROM_RD) begin
        rd_cycles++;
        if (rd_cycles == 1) begin
          rom_reads++;
          rom_a_seen = ROM_A;
        end
        last_rd = rd_cycles;
        ROM_RDY = !rom_stall && (rd_cycles > rom_delay);
      end else begin
        rd_cycles = 0;
        ROM_RDY = 1'b0;
      end
    end
  end

  // Cycle 1 is the cycle REQ rises in; lat is the cycle index where ACK is seen.
  task automatic applyStimulus(input bit ch2, input logic [16:0] addr, input int drop_cyc,
                               input int budget, output int lat);
    bit got;
    @(posedge CLK); #1;
    if (ch2) begin CH2_REQ = 1'b1; CH2_ADDR = addr; end
    else     begin CH1_REQ = 1'b1; CH1_ADDR = addr; end
    lat = 1;
    got = 0;
    while (!got && lat < budget) begin
      @(posedge CLK); #1;
      lat++;
      if (ch2 ? CH2_ACK : CH1_ACK) got = 1;
      if (lat == drop_cyc) begin
        if (ch2) CH2_REQ = 1'b0; else CH1_REQ = 1'b0;
      end
    end
    if (ch2) CH2_REQ = 1'b0; else CH1_REQ = 1'b0;
    if (!got) begin
      checkOutput("ack_wait", 32'd0, 32'd1);
      lat = -1;
    end
  endtask

  task automatic doReset();
    RES = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_rom_rd", ROM_RD, 0);
    checkOutput("rst_rom_a", ROM_A, 0);
    checkOutput("rst_ack1", CH1_ACK, 0);
    checkOutput("rst_ack2", CH2_ACK, 0);
    checkOutput("rst_data1", CH1_DATA, 8'h80);
    checkOutput("rst_data2", CH2_DATA, 8'h80);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_tmo", TMO, 0);
    RES = 1'b0;
  endtask

  int lat, a1, a2, reads0;
  int order[4];

  initial begin
    doReset();

    // Single CH1 fetch, ROM ready one cycle after the strobe
    rom_delay = 1; ROM_D = 8'h3C; a1 = ack1_cnt;
    applyStimulus(0, 17'h00010, 0, 20, lat);
    repeat (2) @(posedge CLK); #1;
    checkOutput("t1_rom_a", rom_a_seen, 17'h00010);
    checkOutput("t1_data1", CH1_DATA, 8'h3C);
    checkOutput("t1_ack1_once", ack1_cnt - a1, 1);
    checkOutput("t1_latency", lat, 4);
    checkOutput("t1_data2_kept", CH2_DATA, 8'h80);
    checkOutput("t1_busy_idle", BUSY, 0);

    // Minimum latency: ROM ready on first READ cycle
    rom_delay = 0; ROM_D = 8'h55;
    applyStimulus(1, 17'h00123, 0, 20, lat);
    checkOutput("t2_latency", lat, 3);
    checkOutput("t2_data2", CH2_DATA, 8'h55);
    checkOutput("t2_data1_kept", CH1_DATA, 8'h3C);

    // Simultaneous requests after reset: alternate CH1, CH2, CH1, CH2
    doReset();
    ROM_D = 8'hA5;
    @(posedge CLK); #1;
    CH1_ADDR = 17'h00100; CH2_ADDR = 17'h00200;
    CH1_REQ = 1'b1; CH2_REQ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      order[k] = 0;
      while (order[k] == 0 && w < 20) begin
        @(posedge CLK); #1;
        w++;
        if (CH1_ACK) order[k] = 1;
        else if (CH2_ACK) order[k] = 2;
      end
      if (order[k] == 1) CH1_REQ = 1'b0;
      if (order[k] == 2) CH2_REQ = 1'b0;
      @(posedge CLK); #1;
      if (k < 3) begin
        if (order[k] == 1) CH1_REQ = 1'b1;
        if (order[k] == 2) CH2_REQ = 1'b1;
      end
    end
    CH1_REQ = 1'b0; CH2_REQ = 1'b0;
    checkOutput("rr_grant0", order[0], 1);
    checkOutput("rr_grant1", order[1], 2);
    checkOutput("rr_grant2", order[2], 1);
    checkOutput("rr_grant3", order[3], 2);
    checkOutput("rr_data1", CH1_DATA, 8'hA5);
    checkOutput("rr_data2", CH2_DATA, 8'hA5);

    // ROM never ready: timeout after 255 READ cycles
    rom_stall = 1; a1 = ack1_cnt;
    applyStimulus(0, 17'h0ABCD, 0, 400, lat);
    checkOutput("tmo_data1", CH1_DATA, 8'h80);
    checkOutput("tmo_flag", TMO, 1);
    checkOutput("tmo_rd_cycles", last_rd, 255);
    checkOutput("tmo_latency", lat, 257);
    @(posedge CLK); #1;
    checkOutput("tmo_rom_rd_low", ROM_RD, 0);
    checkOutput("tmo_ack_once", ack1_cnt - a1, 1);

    // TMO stays set across a later successful fetch
    rom_stall = 0; ROM_D = 8'h11;
    applyStimulus(0, 17'h00001, 0, 20, lat);
    checkOutput("tmo_sticky", TMO, 1);
    checkOutput("after_tmo_data1", CH1_DATA, 8'h11);

    // Reset during the second READ cycle
    rom_stall = 1; a2 = ack2_cnt;
    @(posedge CLK); #1;
    CH2_ADDR = 17'h01234; CH2_REQ = 1'b1;
    repeat (2) @(posedge CLK); #1;
    checkOutput("midrst_reading", ROM_RD, 1);
    RES = 1'b1; CH2_REQ = 1'b0;
    @(posedge CLK); #1;
    checkOutput("midrst_rom_rd", ROM_RD, 0);
    checkOutput("midrst_rom_a", ROM_A, 0);
    checkOutput("midrst_busy", BUSY, 0);
    checkOutput("midrst_tmo", TMO, 0);
    checkOutput("midrst_data1", CH1_DATA, 8'h80);
    checkOutput("midrst_data2", CH2_DATA, 8'h80);
    RES = 1'b0; rom_stall = 0;
    repeat (5) @(posedge CLK); #1;
    checkOutput("midrst_no_ack", ack2_cnt - a2, 0);

    // CH2 withdraws its request in the first READ cycle
    rom_delay = 3; ROM_D = 8'h77; a2 = ack2_cnt;
    applyStimulus(1, 17'h00555, 2, 20, lat);
    repeat (2) @(posedge CLK); #1;
    checkOutput("wd_data2", CH2_DATA, 8'h77);
    checkOutput("wd_ack_once", ack2_cnt - a2, 1);
    checkOutput("wd_idle", BUSY, 0);

    // Same address fetched twice by CH2
    rom_delay = 0; ROM_D = 8'h5A; reads0 = rom_reads;
    applyStimulus(1, 17'h1FFFF, 0, 20, lat);
    checkOutput("rep1_latency", lat, 3);
    checkOutput("rep1_data2", CH2_DATA, 8'h5A);
    ROM_D = 8'hEE;
    applyStimulus(1, 17'h1FFFF, 0, 20, lat);
`ifdef K007232_ROMARB_CACHE_EN
    checkOutput("rep2_latency", lat, 2);
    checkOutput("rep2_data2", CH2_DATA, 8'h5A);
    checkOutput("rep_rom_reads", rom_reads - reads0, 1);
`else
    checkOutput("rep2_latency", lat, 3);
    checkOutput("rep2_data2", CH2_DATA, 8'hEE);
    checkOutput("rep_rom_reads", rom_reads - reads0, 2);
`endif

    repeat (2) @(posedge CLK); #1;
    checkOutput("ack_overlap", overlap, 0);
    checkOutput("rom_rd_while_idle", rd_idle, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
